// File: rtl/dot_accum_argmax.sv
`ifndef VMU_DATA_WIDTH
`define VMU_DATA_WIDTH 16
`endif
// dot_accum_argmax: accumulates partial-sum beats into per-column correlations and tracks the column with the largest |correlation|.
module dot_accum_argmax #(
    parameter int DW    = `VMU_DATA_WIDTH,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_col_last,
    input  logic             in_srch_last,
    output logic             corr_valid,
    output logic [DW-1:0]    corr_data,
    output logic [IDX_W-1:0] corr_idx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_idx,
    output logic [DW-1:0]    res_val,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

    state_t           r_state;
    logic [DW-1:0]    r_acc;
    logic [DW-1:0]    r_col_sum;
    logic [DW-1:0]    r_best_abs;
    logic [DW-1:0]    r_res_val;
    logic [IDX_W-1:0] r_col_idx;
    logic [IDX_W-1:0] r_res_idx;
    logic             r_srch_last;
    logic             r_best_valid;

    logic [DW-1:0]    w_sum;
    logic [DW-1:0]    w_abs;
    logic             w_take;

    assign w_sum  = r_acc + in_data;
    // most negative value has no positive counterpart, so clamp it to the max positive
    assign w_abs  = !r_col_sum[DW-1] ? r_col_sum :
                    (r_col_sum == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}} : -r_col_sum;
    assign w_take = !r_best_valid || (w_abs > r_best_abs);

    assign in_ready   = r_state == ACCUM;
    assign corr_valid = r_state == COMPARE;
    assign corr_data  = r_col_sum;
    assign corr_idx   = r_col_idx;
    assign res_valid  = r_state == DONE;
    assign res_idx    = r_res_idx;
    assign res_val    = r_res_val;
    assign busy       = r_state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_col_sum    <= '0;
            r_best_abs   <= '0;
            r_res_val    <= '0;
            r_col_idx    <= '0;
            r_res_idx    <= '0;
            r_srch_last  <= 1'b0;
            r_best_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_acc        <= '0;
                    r_col_idx    <= '0;
                    r_best_abs   <= '0;
                    r_best_valid <= 1'b0;
                    r_res_idx    <= '0;
                    r_res_val    <= '0;
                    r_state      <= ACCUM;
                end
                ACCUM: if (in_valid) begin
                    if (in_col_last || in_srch_last) begin
                        r_col_sum   <= w_sum;
                        r_srch_last <= in_srch_last;
                        r_acc       <= '0;
                        r_state     <= COMPARE;
                    end else begin
                        r_acc <= w_sum;
                    end
                end
                COMPARE: begin
                    if (w_take) begin
                        r_best_abs   <= w_abs;
                        r_res_val    <= r_col_sum;
                        r_res_idx    <= r_col_idx;
                        r_best_valid <= 1'b1;
                    end
                    r_col_idx <= r_col_idx + 1'b1;
                    r_state   <= r_srch_last ? DONE : ACCUM;
                end
                DONE: if (res_ready) r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dot_accum_argmax.md
DOT_ACCUM_ARGMAX -- requirements
Module: dot_accum_argmax

Interface
REQ-001 SHALL have parameter DW, default `VMU_DATA_WIDTH, giving the signed data width of partial sums and correlations.
REQ-002 SHALL have parameter IDX_W, default 6, giving the width of the column index.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begins a new search; sampled only in IDLE.
REQ-006 in_valid  input  1  in_data carries a valid partial sum.
REQ-007 in_ready  output  1  block accepts a beat; a beat transfers when in_valid and in_ready are both 1.
REQ-008 in_data  input  DW  signed partial sum from the VMU adder tree (scalar, dot-product mode).
REQ-009 in_col_last  input  1  current beat is the last beat of a column.
REQ-010 in_srch_last  input  1  current beat is the last beat of the last column.
REQ-011 corr_valid  output  1  one-cycle pulse: corr_data/corr_idx hold a completed column correlation.
REQ-012 corr_data  output  DW  signed column correlation.
REQ-013 corr_idx  output  IDX_W  index of that column.
REQ-014 res_valid  output  1  search result available; held until accepted.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 res_idx  output  IDX_W  index of the column with maximum |correlation|.
REQ-017 res_val  output  DW  signed correlation of that column.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> ACCUM -> COMPARE -> (ACCUM | DONE) -> IDLE.
REQ-020 IDLE: on start=1, SHALL clear acc, col_idx, the best-value register and the best-valid flag, then enter ACCUM; all other inputs are ignored.
REQ-021 in_ready SHALL be 1 only in ACCUM; it is 0 in IDLE, COMPARE and DONE.
REQ-022 ACCUM: on each accepted beat, acc SHALL become acc + in_data, modulo 2^DW (two's-complement wrap, no saturation).
REQ-023 An accepted beat with in_col_last=1 or in_srch_last=1 SHALL latch acc + in_data into col_sum, latch in_srch_last, clear acc and enter COMPARE.
REQ-024 in_srch_last=1 without in_col_last SHALL be treated as a column end.
REQ-025 COMPARE, one cycle:
- assert corr_valid=1 with corr_data=col_sum and corr_idx=col_idx.
- form abs = |col_sum|, saturating the most negative value to 2^(DW-1)-1.
- if best-valid=0 or abs > best_abs (strictly greater), load best_abs, res_val=col_sum, res_idx=col_idx, and set best-valid.
- increment col_idx, wrapping modulo 2^IDX_W.
- go to DONE if the latched srch_last is 1, else to ACCUM.
REQ-026 Ties SHALL keep the earlier (lower-index) column.
REQ-027 corr_valid SHALL be high exactly in the cycle after the column-ending beat is accepted.
REQ-028 DONE: res_valid=1, with res_idx/res_val stable, until res_valid and res_ready are both 1; the block then enters IDLE in the next cycle.
REQ-029 A final beat accepted at cycle t SHALL give res_valid=1 from cycle t+2.
REQ-030 start asserted outside IDLE SHALL be ignored and SHALL NOT restart the search.
REQ-031 res_idx/res_val SHALL retain their last values in IDLE until the next start clears them.
REQ-032 in_valid=0 in ACCUM SHALL stall the block with no state change.

Reset
REQ-033 rst=1 SHALL immediately force:
- state IDLE;
- acc, col_sum, col_idx, best_abs, best-valid, res_idx and res_val to 0;
- corr_valid, res_valid, in_ready and busy to 0.
REQ-034 Reset mid-search SHALL discard all partial results; no corr_valid or res_valid pulse follows release of reset.

Verification (DW=16, IDX_W=4)
REQ-035 start; 3 columns of 2 beats: (5,3), (-20,4), (7,7) -> corr_data 8, -16, 14 at idx 0, 1, 2; res_idx=1, res_val=-16.
REQ-036 Tie: columns sum to 10 and -10 -> res_idx=0, res_val=10.
REQ-037 Single beat, -32768 with in_srch_last=1 -> corr_data=-32768, res_val=-32768, res_idx=0; abs saturates without error.
REQ-038 Backpressure: hold res_ready=0 for 5 cycles -> res_valid stays 1, outputs stable, in_ready=0; after 1 cycle of res_ready=1 -> IDLE, busy=0.
REQ-039 Wrap: beats 32767 then 1 in one column -> corr_data=-32768; 17 columns -> corr_idx of the 17th is 0.
REQ-040 Assert rst during the second column's beats -> all outputs 0 immediately; a new start then gives correct results from idx 0; start pulsed in COMPARE/DONE has no effect.
